// File: rtl/scan_timer_scheduler.sv
// -----------------------------------------------------------------------------
// scan_timer_scheduler
//
// One shared CNT_W-bit decrementer time-multiplexed across NUM_CH scan-cycle
// timers. Each scan_cycle_clk edge services exactly one channel (round-robin
// pointer). Channels are configured over a cfg valid/ready handshake and
// started/stopped over an always-accepted cmd port.
//
// Ports:
//   scan_cycle_clk  one rising edge per scan cycle
//   rst_n           synchronous, active-low reset
//   cfg_valid/ready config write handshake (ready low while target is RUN)
//   cfg_ch          channel to configure
//   cfg_preset      reload value
//   cfg_mode        0 = one-shot, 1 = periodic auto-reload
//   cmd_valid       command strobe
//   cmd_ch          command target channel
//   cmd_op          00 nop, 01 start, 10 stop, 11 restart
//   ch_enabled      per-channel RUN flag
//   ch_done         per-channel sticky expiry flag
//   ch_expire       per-channel one-tick expiry pulse
//   svc_ch          channel serviced on the next edge
//   svc_count       current count of channel svc_ch
// -----------------------------------------------------------------------------
module scan_timer_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 10,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              scan_cycle_clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_preset,
  input  logic              cfg_mode,
  input  logic              cmd_valid,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [1:0]        cmd_op,
  output logic [NUM_CH-1:0] ch_enabled,
  output logic [NUM_CH-1:0] ch_done,
  output logic [NUM_CH-1:0] ch_expire,
  output logic [CH_W-1:0]   svc_ch,
  output logic [CNT_W-1:0]  svc_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_START   = 2'b01;
  localparam logic [1:0] OP_STOP    = 2'b10;
  localparam logic [1:0] OP_RESTART = 2'b11;

  ch_state_e        state_q  [NUM_CH];
  ch_state_e        state_d  [NUM_CH];
  logic [CNT_W-1:0] preset_q [NUM_CH];
  logic [CNT_W-1:0] preset_d [NUM_CH];
  logic [CNT_W-1:0] count_q  [NUM_CH];
  logic [CNT_W-1:0] count_d  [NUM_CH];
  logic [NUM_CH-1:0] mode_q,   mode_d;
  logic [NUM_CH-1:0] sticky_q, sticky_d;   // periodic-mode done flag
  logic [NUM_CH-1:0] expire_q, expire_d;
  logic [CH_W-1:0]   ptr_q,    ptr_d;

  logic             cfg_we;
  logic [CNT_W-1:0] load_val;

  // The only combinational input-to-output path in the block.
  assign cfg_ready = (state_q[cfg_ch] != ST_RUN);
  assign cfg_we    = cfg_valid && cfg_ready;

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    ptr_d    = ptr_q + CH_W'(1);
    mode_d   = mode_q;
    sticky_d = sticky_q;
    expire_d = '0;
    load_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      preset_d[i] = preset_q[i];
      count_d[i]  = count_q[i];

      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        preset_d[i] = cfg_preset;
        mode_d[i]   = cfg_mode;
      end

      // A same-edge config write is bypassed into the start/restart load.
      load_val = (cfg_we && (cfg_ch == CH_W'(i))) ? cfg_preset : preset_q[i];

      if (cmd_valid && (cmd_ch == CH_W'(i)) && (cmd_op != OP_NOP)) begin
        // Any real command owns the channel this edge; service is skipped.
        unique case (cmd_op)
          OP_START: begin
            if (state_q[i] != ST_RUN) begin
              state_d[i]  = ST_RUN;
              count_d[i]  = load_val;
              sticky_d[i] = 1'b0;
            end
          end
          OP_STOP: begin
            state_d[i]  = ST_IDLE;
            count_d[i]  = '0;
            sticky_d[i] = 1'b0;
          end
          OP_RESTART: begin
            state_d[i]  = ST_RUN;
            count_d[i]  = load_val;
            sticky_d[i] = 1'b0;
          end
          default: ;
        endcase
      end else if ((ptr_q == CH_W'(i)) && (state_q[i] == ST_RUN)) begin
        if (count_q[i] != '0) begin
          count_d[i] = count_q[i] - CNT_W'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (mode_q[i]) begin
            count_d[i]  = preset_q[i];
            sticky_d[i] = 1'b1;
          end else begin
            state_d[i] = ST_DONE;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge scan_cycle_clk) begin
    if (!rst_n) begin
      // NOTE: the per-channel arrays are real state that must read as zero
      // after reset, so they are reset element by element like any flop.
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= ST_IDLE;
        preset_q[i] <= '0;
        count_q[i]  <= '0;
      end
      mode_q   <= '0;
      sticky_q <= '0;
      expire_q <= '0;
      ptr_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        preset_q[i] <= preset_d[i];
        count_q[i]  <= count_d[i];
      end
      mode_q   <= mode_d;
      sticky_q <= sticky_d;
      expire_q <= expire_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_enabled[i] = (state_q[i] == ST_RUN);
      ch_done[i]    = (state_q[i] == ST_DONE) || sticky_q[i];
    end
  end

  assign ch_expire = expire_q;
  assign svc_ch    = ptr_q;
  assign svc_count = count_q[ptr_q];

endmodule

// File: tb/tb_scan_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_scan_timer_scheduler
//
// Directed self-checking bench for scan_timer_scheduler (NUM_CH=4, CNT_W=10).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
// exp_ptr is the bench's own model of the round-robin pointer.
// -----------------------------------------------------------------------------
module tb_scan_timer_scheduler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 10;
  localparam int CH_W   = 2;

  localparam logic [1:0] NOP = 2'b00, START = 2'b01, STOP = 2'b10, RESTART = 2'b11;

  logic              scan_cycle_clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_preset;
  logic              cfg_mode;
  logic              cmd_valid;
  logic [CH_W-1:0]   cmd_ch;
  logic [1:0]        cmd_op;
  logic [NUM_CH-1:0] ch_enabled;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_expire;
  logic [CH_W-1:0]   svc_ch;
  logic [CNT_W-1:0]  svc_count;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;

  scan_timer_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .scan_cycle_clk (scan_cycle_clk),
    .rst_n          (rst_n),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_ch         (cfg_ch),
    .cfg_preset     (cfg_preset),
    .cfg_mode       (cfg_mode),
    .cmd_valid      (cmd_valid),
    .cmd_ch         (cmd_ch),
    .cmd_op         (cmd_op),
    .ch_enabled     (ch_enabled),
    .ch_done        (ch_done),
    .ch_expire      (ch_expire),
    .svc_ch         (svc_ch),
    .svc_count      (svc_count)
  );

  always #5 scan_cycle_clk = ~scan_cycle_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One scan cycle; the pointer model follows the reset seen at the edge.
  task automatic tick();
    logic in_reset;
    in_reset = !rst_n;
    @(posedge scan_cycle_clk);
    #1;
    exp_ptr = in_reset ? 0 : (exp_ptr + 1) % NUM_CH;
  endtask

  task automatic clear_inputs();
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_preset = '0;
    cfg_mode   = 1'b0;
    cmd_valid  = 1'b0;
    cmd_ch     = '0;
    cmd_op     = NOP;
  endtask

  task automatic do_cfg(input int ch, input int preset, input logic mode);
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_preset = CNT_W'(preset); cfg_mode = mode;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_cmd(input int ch, input logic [1:0] op);
    cmd_valid = 1'b1; cmd_ch = CH_W'(ch); cmd_op = op;
    tick();
    cmd_valid = 1'b0; cmd_op = NOP;
  endtask

  // Advance until the next edge services channel p (bounded by NUM_CH).
  task automatic wait_ptr(input int p);
    for (int k = 0; k < NUM_CH && exp_ptr != p; k++) tick();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_enabled", 32'(ch_enabled), 0);
    check("rst_done",    32'(ch_done),    0);
    check("rst_expire",  32'(ch_expire),  0);
    check("rst_svc_ch",  32'(svc_ch),     0);
    check("rst_count",   32'(svc_count),  0);
    rst_n = 1'b1;

    // Idle sweep: pointer runs 1,2,3,0,... and nothing else moves.
    for (int k = 0; k < 8; k++) begin
      tick();
      check("idle_svc_ch", 32'(svc_ch), 32'((k + 1) % 4));
      check("idle_outs",   32'({ch_enabled, ch_done, ch_expire}), 0);
      check("idle_count",  32'(svc_count), 0);
    end

    // One-shot ch1 preset 2, start on an edge with ptr=0 (E0).
    check("cfg_ready_idle", 32'(cfg_ready), 1);
    do_cfg(1, 2, 1'b0);
    wait_ptr(0);
    do_cmd(1, START);                                   // E0
    check("os_e0_ptr",   32'(svc_ch),    1);
    check("os_e0_count", 32'(svc_count), 2);
    repeat (4) tick();                                  // E1..E4
    check("os_e4_count", 32'(svc_count), 1);
    repeat (4) tick();                                  // E5..E8
    check("os_e8_count", 32'(svc_count), 0);
    check("os_e8_en",    32'(ch_enabled), 32'b0010);
    check("os_e8_exp",   32'(ch_expire),  0);
    tick();                                             // E9
    check("os_e9_exp",   32'(ch_expire),  32'b0010);
    check("os_e9_done",  32'(ch_done),    32'b0010);
    check("os_e9_en",    32'(ch_enabled), 0);
    tick();                                             // E10
    check("os_e10_exp",  32'(ch_expire),  0);
    check("os_e10_done", 32'(ch_done),    32'b0010);

    // Periodic ch2 preset 0: expires every 4 edges and stays RUN.
    do_cfg(2, 0, 1'b1);
    wait_ptr(0);
    do_cmd(2, START);
    tick();
    tick();                                             // ptr=2 visit
    check("per_exp1",  32'(ch_expire[2]),  1);
    check("per_en",    32'(ch_enabled[2]), 1);
    check("per_done",  32'(ch_done[2]),    1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("per_gap", 32'(ch_expire[2]), 0);
    end
    tick();
    check("per_exp2",  32'(ch_expire[2]),  1);
    check("per_en2",   32'(ch_enabled[2]), 1);
    do_cmd(2, STOP);
    check("per_stop",  32'({ch_enabled[2], ch_done[2], ch_expire[2]}), 0);

    // Busy-channel config on ch0.
    do_cfg(0, 3, 1'b0);
    do_cmd(0, START);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_preset = 10'd9; cfg_mode = 1'b0;
    #1;
    check("busy_ready", 32'(cfg_ready), 0);
    wait_ptr(3);
    do_cmd(0, RESTART);              // loads the old preset 3, not 9
    check("busy_keep",  32'(svc_count), 3);
    do_cmd(0, STOP);
    check("busy_ready_after_stop", 32'(cfg_ready), 1);
    tick();                          // held request is written here
    clear_inputs();
    wait_ptr(3);
    do_cmd(0, START);
    check("busy_write_landed", 32'(svc_count), 9);
    do_cmd(0, STOP);

    // Collision: restart ch3 on the visit where count3=0.
    do_cfg(3, 2, 1'b0);
    wait_ptr(3);
    do_cmd(3, START);                // colliding start, count3=2
    wait_ptr(3); tick();             // 2 -> 1
    wait_ptr(3); tick();             // 1 -> 0
    wait_ptr(3);
    check("col_pre_count", 32'(svc_count), 0);
    check("col_pre_en",    32'(ch_enabled[3]), 1);
    do_cmd(3, RESTART);
    check("col_no_exp",    32'(ch_expire[3]), 0);
    check("col_done",      32'(ch_done[3]),   0);
    wait_ptr(3);
    check("col_reload",    32'(svc_count), 2);
    check("col_en",        32'(ch_enabled[3]), 1);
    do_cmd(3, STOP);

    // Simultaneous cfg + start on ch0 uses the new preset.
    wait_ptr(3);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_preset = 10'd5; cfg_mode = 1'b0;
    cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_op = START;
    tick();
    clear_inputs();
    check("byp_count", 32'(svc_count), 5);
    check("byp_en",    32'(ch_enabled[0]), 1);
    do_cmd(0, STOP);

    // Reset mid-run with a start presented on the reset edge.
    do_cfg(1, 7, 1'b0);
    wait_ptr(0);
    do_cmd(1, START);
    check("mid_count", 32'(svc_count), 7);
    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_op = START;
    tick();
    clear_inputs();
    rst_n = 1'b1;
    check("mid_rst_outs",  32'({ch_enabled, ch_done, ch_expire}), 0);
    check("mid_rst_ptr",   32'(svc_ch),    0);
    check("mid_rst_count", 32'(svc_count), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_post_count", 32'(svc_count), 0);
      check("mid_post_outs",  32'({ch_enabled, ch_done, ch_expire}), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
